mouse_trakball: RTL and testbench
=================================

Name: mouse_trakball

Overview:
- Converts PS/2 mouse packets into Atari trak-ball/ST-mouse quadrature signals on the joystick direction lines.
- Sits between the hps_io ps2_mouse output and the JOY1 input of atari800top.
- When not active, joystick 0 passes through unchanged with one cycle of latency.
- Motion is accumulated per axis and replayed as rate-limited Gray-code steps, so software polling POKEY/PIA sees every step.

Parameters:
- STEP_DIV, 2000: clk_sys cycles per quadrature step tick. Minimum 2.
- MAX_ACC, 127: saturation magnitude of each axis accumulator. Range 1..255.
- SHIFT, 0: arithmetic right shift applied to each mouse delta (sensitivity). Range 0..3.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: trak-ball mode allowed (OSD option).
- halt, in, 1: cpu_halt. Clears the mode while high.
- ps2_mouse, in, 25: hps_io mouse packet. [0] left button, [1] right button, [4] X sign, [5] Y sign, [15:8] dx, [23:16] dy, [24] strobe (toggles per packet).
- joy_in, in, 9: digital joystick 0, MiSTer bit order: [0]R [1]L [2]D [3]U [4]F1 [5]F2 ...
- joy_out, out, 9: to atari800top JOY1. Registered.
- active, out, 1: trak-ball mode currently engaged.

Behaviour:
- Reset (sync): acc_x = acc_y = 0, phase_x = phase_y = 0, div = 0, active = 0, joy_out = 0, old_stb <= ps2_mouse[24]. Capturing old_stb at reset prevents a false strobe after reset.
- Strobe: the cycle where ps2_mouse[24] != old_stb. old_stb updates every cycle.
- Deltas, 9-bit signed:
  - dx = {ps2_mouse[4], ps2_mouse[15:8]} >>> SHIFT
  - dy = -({ps2_mouse[5], ps2_mouse[23:16]} >>> SHIFT). Y is inverted so that mouse-up means Atari-up.
- Divider: div counts 0..STEP_DIV-1 and wraps. tick = (div == STEP_DIV-1). The divider free-runs regardless of mode.
- Per-axis update each cycle, computed in 11-bit signed:
  - step = +1 if tick and acc > 0; -1 if tick and acc < 0; else 0.
  - acc_next = sat(acc + (strobe & active_or_arming ? delta : 0) - step), clamped to [-MAX_ACC, +MAX_ACC].
  - The step is decided from the pre-update acc. A strobe and a tick in the same cycle apply both.
- Phase: 2-bit Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  - step = +1 advances forward; step = -1 moves backward; wraps in both directions.
- Mode control, evaluated in priority order:
  1. If halt, or !enable, or joy_in[3:0] != 0: active <= 0, acc = 0, phase = 0. Any strobe that cycle is ignored.
  2. Else if strobe: active <= 1, and the delta that armed the mode is accumulated that same cycle ("arming").
  3. Else active holds.
- Output, registered, computed from next-state values, so 1-cycle latency:
  - When active:
    - joy_out[0] = phase_x[1], joy_out[1] = phase_x[0]
    - joy_out[2] = phase_y[1], joy_out[3] = phase_y[0]
    - joy_out[4] = joy_in[4] | ps2_mouse[0]
    - joy_out[5] = joy_in[5] | ps2_mouse[1]
    - joy_out[8:6] = joy_in[8:6]
  - When inactive: joy_out = joy_in.
- active output = active register.
- Buttons are level-sampled every cycle, not only on strobe.
- Saturation: excess motion beyond ±MAX_ACC is discarded. No wrap.
- Reset mid-step: all state returns to its reset values on the next edge. No partial phase is retained.

Test Plan:
1. Reset held 3 cycles, then released, with joy_in = 9'h1F and enable = 0 -> during reset joy_out = 0 and active = 0; one cycle after release joy_out = 9'h1F.
2. STEP_DIV = 4, enable = 1, strobe with dx = +3, dy = 0 -> active = 1 the next cycle. Over the next 3 ticks joy_out[1:0] goes 00 -> 10 -> 11 -> 01 (phase 01, 11, 10). acc_x ends at 0 and no further change follows.
3. STEP_DIV = 4, MAX_ACC = 127, strobe with dx = -200 -> acc_x = -127. Exactly 127 backward steps follow, and the final phase_x = 01.
4. Strobe dx = +5 issued on the same cycle as a tick, with acc_x = 2 -> acc_x = 6 the next cycle (2 + 5 - 1). phase_x advances once.
5. While active with acc_x = 40, assert joy_in[3] = 1 -> active = 0, acc_x = 0, joy_out = joy_in one cycle later. A strobe in that same cycle is ignored.
6. With active = 1 and mouse left button held, joy_out[4] = 1. Pulse halt for 1 cycle -> active = 0 and joy_out[4] follows joy_in[4] only.

Source files
------------

// File: rtl/mouse_trakball_if.sv
// Bus between the OSD/mouse/joystick side and the trak-ball converter.
interface mouse_trakball_if;
  logic        enable;
  logic        halt;
  logic [24:0] ps2_mouse;
  logic [8:0]  joy_in;
  logic [8:0]  joy_out;
  logic        active;

  modport master (output enable, halt, ps2_mouse, joy_in, input joy_out, active);
  modport slave  (input enable, halt, ps2_mouse, joy_in, output joy_out, active);
endinterface

// File: rtl/mouse_trakball.sv
// PS/2 mouse -> Atari trak-ball quadrature on the joystick direction lines.
// Mouse deltas are accumulated per axis and replayed as one Gray-code step
// per divider tick, so a slow polling loop never misses a transition.
module mouse_trakball #(
  parameter int STEP_DIV = 2000,
  parameter int MAX_ACC  = 127,
  parameter int SHIFT    = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  mouse_trakball_if.slave   bus
);
  localparam int DW = $clog2(STEP_DIV);
  localparam logic signed [10:0] LIM = 11'(MAX_ACC);

  typedef enum logic {S_IDLE, S_TRACK} state_t;

  state_t             r_state, w_state_nxt;
  logic [DW-1:0]      r_div;
  logic               r_old_stb;
  logic signed [8:0]  r_acc_x, r_acc_y, w_acc_x_nxt, w_acc_y_nxt;
  logic [1:0]         r_ph_x, r_ph_y, w_ph_x_nxt, w_ph_y_nxt;
  logic [8:0]         r_joy, w_joy_nxt;
  logic               w_tick, w_stb, w_clear, w_add;
  logic signed [8:0]  w_raw_x, w_raw_y;
  logic signed [10:0] w_dx, w_dy, w_step_x, w_step_y;
  logic               w_unused;

  // Step direction is taken from the accumulator before this cycle's update.
  function automatic logic signed [10:0] f_step(input logic tick, input logic signed [8:0] acc);
    if (tick && !acc[8] && acc != 9'sd0) return 11'sd1;
    if (tick && acc[8])                  return -11'sd1;
    return 11'sd0;
  endfunction

  // Accumulate with clamping; motion past the limit is simply dropped.
  function automatic logic signed [8:0] f_acc(input logic signed [8:0] acc,
                                             input logic signed [10:0] add,
                                             input logic signed [10:0] step);
    logic signed [10:0] s;
    s = $signed({{2{acc[8]}}, acc}) + add - step;
    if (s > LIM)       s = LIM;
    else if (s < -LIM) s = -LIM;
    return s[8:0];
  endfunction

  // Gray -> binary, +/-1 mod 4, binary -> Gray.
  function automatic logic [1:0] f_phase(input logic [1:0] g, input logic [1:0] step);
    logic [1:0] b;
    b = {g[1], g[1] ^ g[0]} + step;
    return {b[1], b[1] ^ b[0]};
  endfunction

  assign w_unused = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};
  assign w_raw_x  = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
  assign w_raw_y  = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
  // Y negated at 11 bits so a -256 raw delta cannot overflow back to -256.
  assign w_dx     = $signed({{2{w_raw_x[8]}}, w_raw_x}) >>> SHIFT;
  assign w_dy     = -($signed({{2{w_raw_y[8]}}, w_raw_y}) >>> SHIFT);
  assign w_tick   = (r_div == DW'(STEP_DIV - 1));
  assign w_stb    = bus.ps2_mouse[24] ^ r_old_stb;
  assign w_clear  = bus.halt | ~bus.enable | (|bus.joy_in[3:0]);
  assign w_add    = w_stb & ~w_clear;
  assign w_step_x = f_step(w_tick, r_acc_x);
  assign w_step_y = f_step(w_tick, r_acc_y);

  // Mode FSM: any strobe arms tracking; halt, disable or real joystick drops it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear)    w_state_nxt = S_IDLE;
    else if (w_stb) w_state_nxt = S_TRACK;
  end

  // Next accumulator/phase values and the output word built from them.
  always_comb begin
    w_acc_x_nxt = 9'sd0;
    w_acc_y_nxt = 9'sd0;
    w_ph_x_nxt  = 2'b00;
    w_ph_y_nxt  = 2'b00;
    if (!w_clear) begin
      w_acc_x_nxt = f_acc(r_acc_x, w_add ? w_dx : 11'sd0, w_step_x);
      w_acc_y_nxt = f_acc(r_acc_y, w_add ? w_dy : 11'sd0, w_step_y);
      w_ph_x_nxt  = f_phase(r_ph_x, w_step_x[1:0]);
      w_ph_y_nxt  = f_phase(r_ph_y, w_step_y[1:0]);
    end
    w_joy_nxt = bus.joy_in;
    if (w_state_nxt == S_TRACK)
      w_joy_nxt = {bus.joy_in[8:6],
                   bus.joy_in[5] | bus.ps2_mouse[1],
                   bus.joy_in[4] | bus.ps2_mouse[0],
                   w_ph_y_nxt[0], w_ph_y_nxt[1],
                   w_ph_x_nxt[0], w_ph_x_nxt[1]};
  end

  // State registers; old strobe is captured even in reset to avoid a false packet.
  always_ff @(posedge clk_sys) begin
    r_old_stb <= bus.ps2_mouse[24];
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_acc_x <= 9'sd0;
      r_acc_y <= 9'sd0;
      r_ph_x  <= 2'b00;
      r_ph_y  <= 2'b00;
      r_joy   <= 9'h000;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_acc_x <= w_acc_x_nxt;
      r_acc_y <= w_acc_y_nxt;
      r_ph_x  <= w_ph_x_nxt;
      r_ph_y  <= w_ph_y_nxt;
      r_joy   <= w_joy_nxt;
    end
  end

  assign bus.joy_out = r_joy;
  assign bus.active  = (r_state == S_TRACK);
endmodule

// File: tb/tb_mouse_trakball.sv
// Directed bench for mouse_trakball with STEP_DIV=4: a vector table for the
// cycle-by-cycle walk, then hand-written sequences for the long corner cases.
module tb_mouse_trakball;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   tb_div = 0;
  logic stb = 1'b0;

  mouse_trakball_if bus();

  mouse_trakball #(.STEP_DIV(4), .MAX_ACC(127), .SHIFT(0)) dut (
    .clk_sys(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, halt;
    logic [24:0] ps2;
    logic [8:0]  joy;
    int          n;
    logic [8:0]  exp_joy;
    logic        exp_act;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [24:0] ms(input logic s, input logic lb, input int dx, input int dy);
    logic [24:0] p;
    logic [8:0]  x, y;
    x = dx[8:0];
    y = dy[8:0];
    p = '0;
    p[24] = s;  p[0] = lb;
    p[4] = x[8];  p[15:8] = x[7:0];
    p[5] = y[8];  p[23:16] = y[7:0];
    return p;
  endfunction

  task automatic add(input logic r, input logic e, input logic h, input logic [24:0] p,
                     input logic [8:0] j, input int n, input logic [8:0] ej, input logic ea);
    vec_t v;
    v.rst = r; v.en = e; v.halt = h; v.ps2 = p; v.joy = j;
    v.n = n; v.exp_joy = ej; v.exp_act = ea;
    tbl.push_back(v);
  endtask

  // One clock; tb_div mirrors the free-running divider (value before the edge).
  task automatic cyc();
    @(posedge clk);
    if (rst) tb_div = 0; else tb_div = (tb_div + 1) % 4;
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic strobe(input logic lb, input int dx, input int dy);
    stb = ~stb;
    bus.ps2_mouse = ms(stb, lb, dx, dy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [1:0] prev;
    rst = 1'b1; bus.enable = 1'b0; bus.halt = 1'b0;
    bus.ps2_mouse = ms(1'b0, 1'b0, 0, 0); bus.joy_in = 9'h1F;

    // Edge index k after release: edges with k%4==3 are ticks.
    add(1, 0, 0, ms(0, 0, 0, 0), 9'h01F, 3, 9'h000, 0);   // in reset
    add(0, 0, 0, ms(0, 0, 0, 0), 9'h01F, 1, 9'h01F, 0);   // k0 passthrough
    add(0, 0, 0, ms(0, 0, 0, 0), 9'h1A5, 1, 9'h1A5, 0);   // k1
    add(0, 1, 0, ms(0, 0, 0, 0), 9'h100, 1, 9'h100, 0);   // k2 enabled, no packet
    add(0, 1, 0, ms(0, 0, 0, 0), 9'h000, 1, 9'h000, 0);   // k3
    add(0, 1, 0, ms(1, 0, 3, 0), 9'h000, 1, 9'h000, 1);   // k4 arm dx=+3
    add(0, 1, 0, ms(1, 0, 3, 0), 9'h000, 2, 9'h000, 1);   // k5-6
    add(0, 1, 0, ms(1, 0, 3, 0), 9'h000, 4, 9'h002, 1);   // k7-10 phase 01
    add(0, 1, 0, ms(1, 0, 3, 0), 9'h000, 4, 9'h003, 1);   // k11-14 phase 11
    add(0, 1, 0, ms(1, 0, 3, 0), 9'h000, 1, 9'h001, 1);   // k15 phase 10
    add(0, 1, 0, ms(1, 1, 3, 0), 9'h020, 4, 9'h031, 1);   // k16-19 buttons, no more steps
    add(0, 1, 0, ms(0, 0, 0, 1), 9'h000, 3, 9'h001, 1);   // k20-22 dy=+1 (up)
    add(0, 1, 0, ms(0, 0, 0, 1), 9'h000, 2, 9'h005, 1);   // k23-24 Y backward to 10
    add(0, 1, 0, ms(1, 0, 5, 0), 9'h008, 1, 9'h008, 0);   // k25 joystick U wins, strobe ignored
    add(0, 1, 0, ms(1, 0, 5, 0), 9'h000, 2, 9'h000, 0);   // k26-27 stays idle

    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.enable = tbl[i].en; bus.halt = tbl[i].halt;
      bus.ps2_mouse = tbl[i].ps2; bus.joy_in = tbl[i].joy;
      for (int r = 0; r < tbl[i].n; r++) begin
        cyc();
        chk($sformatf("vec%0d.%0d joy_out", i, r), int'(bus.joy_out), int'(tbl[i].exp_joy));
        chk($sformatf("vec%0d.%0d active", i, r), int'(bus.active), int'(tbl[i].exp_act));
      end
    end
    stb = 1'b1;

    // Saturation to -127 then exactly 127 backward steps.
    while (tb_div != 0) cyc();
    strobe(1'b0, -200, 0);
    cyc();
    chk("sat acc_x", int'($signed(dut.r_acc_x)), -127);
    chk("sat active", int'(bus.active), 1);
    prev = bus.joy_out[1:0];
    cnt = 0;
    repeat (520) begin
      cyc();
      if (bus.joy_out[1:0] != prev) cnt++;
      prev = bus.joy_out[1:0];
    end
    chk("back step count", cnt, 127);
    chk("back final joy[1:0]", int'(bus.joy_out[1:0]), 2);
    chk("back acc_x", int'($signed(dut.r_acc_x)), 0);

    // Strobe coinciding with a tick: 2 + 5 - 1.
    while (tb_div != 0) cyc();
    strobe(1'b0, 2, 0);
    cyc();
    chk("pre-tick acc_x", int'($signed(dut.r_acc_x)), 2);
    cyc(); cyc();
    strobe(1'b0, 5, 0);
    cyc();
    chk("tick+strobe acc_x", int'($signed(dut.r_acc_x)), 6);
    chk("tick+strobe joy[1:0]", int'(bus.joy_out[1:0]), 3);

    // Joystick direction drops the mode and eats a same-cycle strobe.
    strobe(1'b0, 34, 0);
    cyc();
    chk("acc_x 40", int'($signed(dut.r_acc_x)), 40);
    bus.joy_in = 9'h008;
    strobe(1'b0, 5, 0);
    cyc();
    chk("joyU active", int'(bus.active), 0);
    chk("joyU joy_out", int'(bus.joy_out), 9'h008);
    chk("joyU acc_x", int'($signed(dut.r_acc_x)), 0);
    bus.joy_in = 9'h000;
    cyc();
    chk("joyU after active", int'(bus.active), 0);
    chk("joyU after joy_out", int'(bus.joy_out), 0);

    // Left button merged while active; halt pulse drops it.
    strobe(1'b1, 0, 0);
    cyc();
    chk("btn active", int'(bus.active), 1);
    chk("btn joy_out", int'(bus.joy_out), 9'h010);
    bus.halt = 1'b1;
    cyc();
    chk("halt active", int'(bus.active), 0);
    chk("halt joy_out", int'(bus.joy_out), 0);
    bus.halt = 1'b0;
    cyc();
    chk("post-halt active", int'(bus.active), 0);
    chk("post-halt joy_out", int'(bus.joy_out), 0);
    bus.joy_in = 9'h010;
    cyc();
    chk("post-halt F1 passthru", int'(bus.joy_out), 9'h010);

    // Y saturation with inversion: mouse -128 becomes +128, clamped to 127.
    bus.joy_in = 9'h000;
    strobe(1'b0, 0, -128);
    cyc();
    chk("sat acc_y", int'($signed(dut.r_acc_y)), 127);
    chk("sat y active", int'(bus.active), 1);

    // Reset mid-motion, with a strobe toggle while in reset.
    rst = 1'b1;
    strobe(1'b0, 7, 0);
    cyc();
    chk("rst joy_out", int'(bus.joy_out), 0);
    chk("rst active", int'(bus.active), 0);
    cyc();
    rst = 1'b0;
    bus.joy_in = 9'h0C0;
    cyc();
    chk("post-rst active", int'(bus.active), 0);
    chk("post-rst joy_out", int'(bus.joy_out), 9'h0C0);
    chk("post-rst acc_y", int'($signed(dut.r_acc_y)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
